phy_tx_serializer: RTL and testbench
====================================

# phy_tx_serializer

Two-lane PHY transmit serializer, the transmit-side counterpart of the PHY receive path. Accepts one byte plus valid flag per lane every 8 clock cycles and shifts it out MSB-first on a 1-bit serial line per lane, substituting the COM symbol when no valid data is offered. After reset it emits a fixed number of COM symbols on both lanes so the far-end receiver can achieve byte alignment before data flows. Runs entirely in the `clk_8f` domain and sits between the lane distributor and the serial link.

## Interface
- `COM_SYMBOL`, 8'hBC, idle/alignment symbol sent when no valid byte is accepted
- `SYNC_COUNT`, 4, number of COM symbols sent on each lane after reset before data is accepted (range 1..15)

- `clk_8f`  in  1  bit clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk_8f`
- `data_in_c_0`  in  8  lane 0 parallel byte
- `valid_in_c_0`  in  1  lane 0 byte valid
- `data_in_c_1`  in  8  lane 1 parallel byte
- `valid_in_c_1`  in  1  lane 1 byte valid
- `ready`  out  1  inputs are sampled on the next rising edge (shared by both lanes)
- `sync_done`  out  1  initial COM sequence committed; high from load of last COM symbol onward
- `data_out_c_0`  out  1  lane 0 serial output
- `data_out_c_1`  out  1  lane 1 serial output

## Operation
- Internal state: 3-bit `bit_cnt` (shared), 8-bit shift register per lane, 4-bit `sync_cnt`, state in {INIT, ACTIVE}.
- `data_out_c_x` = MSB of lane shift register (registered; no combinational path from inputs).
- Reset (`reset`==0 at edge): shift registers 0, `bit_cnt`=7, `sync_cnt`=0, state INIT. Outputs: `data_out_c_x`=0, `ready`=0, `sync_done`=0.
- Load edge: any edge with `reset`==1 and `bit_cnt`==7. At load edge `bit_cnt`<=0 and each lane's shift register loads its next symbol; otherwise shift register shifts left by 1 (zero-fill) and `bit_cnt` increments.
- INIT: every load loads `COM_SYMBOL` on both lanes, `sync_cnt` increments. Load with `sync_cnt`==`SYNC_COUNT`-1 also moves state to ACTIVE. Inputs ignored.
- ACTIVE: per lane independently, load `data_in_c_x` if `valid_in_c_x`==1, else `COM_SYMBOL`. Data byte equal to `COM_SYMBOL` is sent unchanged (no escaping).
- `ready` = (state==ACTIVE) && (`bit_cnt`==7), combinational from registers.
- `sync_done` = (state==ACTIVE).
- No backpressure: upstream must present data when `ready` is high; a byte not present is lost and COM is sent instead.

## Timing
- Edge numbering: edge 0 = last edge with `reset`==0; edge n = n-th edge after.
- COM loads at edges 1, 9, 17, ..., 1+8·(`SYNC_COUNT`-1). With default 4: loads at 1, 9, 17, 25; `sync_done` high after edge 25.
- First `ready` high between edges 32 and 33 (default); first input sample at edge 33; thereafter sample every 8 edges (41, 49, ...).
- Latency: byte sampled at edge E appears as bit7 on `data_out_c_x` after E, bit0 after E+7; next symbol's bit7 after E+8. No gaps between symbols.
- `ready` is high exactly 1 cycle in 8 in ACTIVE; never high in INIT.
- Both lanes are bit-aligned at all times (shared `bit_cnt`).
- Reset mid-symbol: at the reset edge, outputs go to 0 immediately after that edge; in-flight bits discarded; full COM sequence restarts after release.
- `valid_in` toggling between load edges has no effect; only value at load edge matters.

## Test plan
- Reset release, inputs idle: both lanes emit 1011_1100 repeated 4 times (edges 1-32), `sync_done` rises after edge 25, `ready` first high before edge 33 -> pass.
- ACTIVE, lane 0 `data_in`=8'hA5 valid=1, lane 1 valid=0 at edge 33: lane 0 bits after edges 33..40 = 1,0,1,0,0,1,0,1; lane 1 = 1,0,1,1,1,1,0,0.
- Back-to-back bytes 8'h01, 8'h80, 8'hFF on lane 1 at edges 33, 41, 49: continuous stream 00000001 10000000 11111111, no idle bits between.
- Valid asserted only between load edges (e.g. high edges 34-40, low at 41): COM sent for symbol loaded at 41; input ignored.
- Reset asserted at edge 45 mid-byte: outputs 0, `ready`=0, `sync_done`=0 after edge 45; after release, 4 COM symbols resent before next `ready`.
- `SYNC_COUNT`=1: single COM loaded at edge 1, `sync_done` after edge 1, first sample at edge 9.

Source files
------------

// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: one byte per lane every 8 clocks, shifted out MSB-first.
// After reset both lanes send SYNC_COUNT COM symbols so the far end can lock byte alignment.
module phy_tx_serializer #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in_c_0,
    input  logic       valid_in_c_0,
    input  logic [7:0] data_in_c_1,
    input  logic       valid_in_c_1,
    output logic       ready,
    output logic       sync_done,
    output logic       data_out_c_0,
    output logic       data_out_c_1
);

    typedef enum logic {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic [7:0] shift0_q, shift0_d;
    logic [7:0] shift1_q, shift1_d;
    logic       load;

    assign load = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        sync_cnt_d = sync_cnt_q;
        shift0_d   = {shift0_q[6:0], 1'b0};
        shift1_d   = {shift1_q[6:0], 1'b0};
        if (load) begin
            bit_cnt_d = 3'd0;
            if (state_q == ST_INIT) begin
                shift0_d   = COM_SYMBOL;
                shift1_d   = COM_SYMBOL;
                sync_cnt_d = sync_cnt_q + 4'd1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end else begin
                // Lanes are independent: a missing byte on one lane becomes COM there only.
                shift0_d = valid_in_c_0 ? data_in_c_0 : COM_SYMBOL;
                shift1_d = valid_in_c_1 ? data_in_c_1 : COM_SYMBOL;
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            bit_cnt_q  <= 3'd7;
            sync_cnt_q <= 4'd0;
            shift0_q   <= 8'd0;
            shift1_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            shift0_q   <= shift0_d;
            shift1_q   <= shift1_d;
        end
    end

    assign data_out_c_0 = shift0_q[7];
    assign data_out_c_1 = shift1_q[7];
    assign sync_done    = (state_q == ST_ACTIVE);
    assign ready        = (state_q == ST_ACTIVE) && load;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: table vectors, corner-case sequences and a random phase,
// all checked against an edge-index reference model of the transmit timing.
module tb_phy_tx_serializer;

    localparam logic [7:0] COM = 8'hBC;
    localparam int S0 = 4;
    localparam int S1 = 1;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in_c_0 = 8'd0;
    logic       valid_in_c_0 = 1'b0;
    logic [7:0] data_in_c_1 = 8'd0;
    logic       valid_in_c_1 = 1'b0;

    logic ready_a, sync_done_a, out0_a, out1_a;
    logic ready_b, sync_done_b, out0_b, out1_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_8f = ~clk_8f;

    phy_tx_serializer #(.COM_SYMBOL(COM), .SYNC_COUNT(S0)) dut_a (
        .clk_8f(clk_8f), .reset(reset),
        .data_in_c_0(data_in_c_0), .valid_in_c_0(valid_in_c_0),
        .data_in_c_1(data_in_c_1), .valid_in_c_1(valid_in_c_1),
        .ready(ready_a), .sync_done(sync_done_a),
        .data_out_c_0(out0_a), .data_out_c_1(out1_a)
    );

    phy_tx_serializer #(.COM_SYMBOL(COM), .SYNC_COUNT(S1)) dut_b (
        .clk_8f(clk_8f), .reset(reset),
        .data_in_c_0(data_in_c_0), .valid_in_c_0(valid_in_c_0),
        .data_in_c_1(data_in_c_1), .valid_in_c_1(valid_in_c_1),
        .ready(ready_b), .sync_done(sync_done_b),
        .data_out_c_0(out0_b), .data_out_c_1(out1_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = edges since the last reset edge; symbol k occupies edges 1+8k..8+8k.
    int         n = 0;
    bit         mvalid = 1'b0;
    logic [7:0] sym [2][2];

    function automatic int sc(input int inst);
        return (inst == 0) ? S0 : S1;
    endfunction

    always @(posedge clk_8f) begin
        if (!reset) begin
            n = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            n = n + 1;
            if ((n - 1) % 8 == 0) begin
                for (int i = 0; i < 2; i++) begin
                    if ((n - 1) / 8 >= sc(i)) begin
                        sym[i][0] = valid_in_c_0 ? data_in_c_0 : COM;
                        sym[i][1] = valid_in_c_1 ? data_in_c_1 : COM;
                    end else begin
                        sym[i][0] = COM;
                        sym[i][1] = COM;
                    end
                end
            end
        end
    end

    function automatic logic exp_bit(input int inst, input int lane);
        logic [7:0] s;
        if (n == 0) return 1'b0;
        s = sym[inst][lane];
        return s[7 - ((n - 1) % 8)];
    endfunction

    always @(negedge clk_8f) begin
        if (mvalid) begin
            chk("mon_a_out0", 32'(out0_a), 32'(exp_bit(0, 0)));
            chk("mon_a_out1", 32'(out1_a), 32'(exp_bit(0, 1)));
            chk("mon_a_ready", 32'(ready_a), 32'(n >= 8 * S0 && n % 8 == 0));
            chk("mon_a_sync_done", 32'(sync_done_a), 32'(n >= 1 + 8 * (S0 - 1)));
            chk("mon_b_out0", 32'(out0_b), 32'(exp_bit(1, 0)));
            chk("mon_b_out1", 32'(out1_b), 32'(exp_bit(1, 1)));
            chk("mon_b_ready", 32'(ready_b), 32'(n >= 8 * S1 && n % 8 == 0));
            chk("mon_b_sync_done", 32'(sync_done_b), 32'(n >= 1 + 8 * (S1 - 1)));
        end
    end

    typedef struct {
        logic [7:0] d0;
        logic       v0;
        logic [7:0] d1;
        logic       v1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [7];

    task automatic wait_ready(input string name);
        int k;
        for (k = 0; k < 64; k++) begin
            if (ready_a === 1'b1) break;
            @(negedge clk_8f);
        end
        if (k == 64) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: ready timeout got 0 expected 1", name);
        end
    endtask

    task automatic capture8(output logic [7:0] b0, output logic [7:0] b1);
        b0 = 8'd0;
        b1 = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_8f);
            b0 = {b0[6:0], out0_a};
            b1 = {b1[6:0], out1_a};
        end
    endtask

    initial begin
        logic [31:0] stream0, stream1;
        logic [7:0]  g0, g1;
        int          cnt;

        vecs[0] = '{8'hA5, 1'b1, 8'h00, 1'b0, 8'hA5, COM};
        vecs[1] = '{8'h00, 1'b0, 8'h01, 1'b1, COM,   8'h01};
        vecs[2] = '{8'h00, 1'b0, 8'h80, 1'b1, COM,   8'h80};
        vecs[3] = '{8'h00, 1'b0, 8'hFF, 1'b1, COM,   8'hFF};
        vecs[4] = '{COM,   1'b1, COM,   1'b1, COM,   COM};
        vecs[5] = '{8'h3C, 1'b1, 8'hC3, 1'b0, 8'h3C, COM};
        vecs[6] = '{8'hFF, 1'b0, 8'h00, 1'b1, COM,   8'h00};

        repeat (3) @(negedge clk_8f);
        chk("reset_out0", 32'(out0_a), 32'd0);
        chk("reset_out1", 32'(out1_a), 32'd0);
        chk("reset_ready", 32'(ready_a), 32'd0);
        chk("reset_sync_done", 32'(sync_done_a), 32'd0);

        // Idle release: four COM symbols, sync_done after edge 25, ready after edge 32.
        reset = 1'b1;
        stream0 = 32'd0;
        stream1 = 32'd0;
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk_8f);
            stream0 = {stream0[30:0], out0_a};
            stream1 = {stream1[30:0], out1_a};
            if (e == 1)  chk("b_sync_done_edge1", 32'(sync_done_b), 32'd1);
            if (e == 8)  chk("b_ready_edge8", 32'(ready_b), 32'd1);
            if (e == 24) chk("sync_done_edge24", 32'(sync_done_a), 32'd0);
            if (e == 25) chk("sync_done_edge25", 32'(sync_done_a), 32'd1);
            if (e == 31) chk("ready_edge31", 32'(ready_a), 32'd0);
            if (e == 32) chk("ready_edge32", 32'(ready_a), 32'd1);
        end
        chk("com_stream_lane0", stream0, {4{COM}});
        chk("com_stream_lane1", stream1, {4{COM}});

        // Back-to-back table vectors, one per 8-cycle slot.
        for (int i = 0; i < 7; i++) begin
            wait_ready("vec_ready");
            data_in_c_0  = vecs[i].d0;
            valid_in_c_0 = vecs[i].v0;
            data_in_c_1  = vecs[i].d1;
            valid_in_c_1 = vecs[i].v1;
            capture8(g0, g1);
            chk($sformatf("vec%0d_lane0", i), 32'(g0), 32'(vecs[i].e0));
            chk($sformatf("vec%0d_lane1", i), 32'(g1), 32'(vecs[i].e1));
        end

        // Valid high only between load edges: the following load must still send COM.
        wait_ready("between_ready");
        valid_in_c_0 = 1'b0;
        valid_in_c_1 = 1'b0;
        @(negedge clk_8f);
        data_in_c_0  = 8'h55;
        data_in_c_1  = 8'hAA;
        valid_in_c_0 = 1'b1;
        valid_in_c_1 = 1'b1;
        repeat (7) @(negedge clk_8f);
        valid_in_c_0 = 1'b0;
        valid_in_c_1 = 1'b0;
        capture8(g0, g1);
        chk("between_lane0", 32'(g0), 32'(COM));
        chk("between_lane1", 32'(g1), 32'(COM));

        // Reset mid-symbol, then the full COM sequence again before ready.
        wait_ready("midreset_ready");
        data_in_c_0  = 8'h0F;
        valid_in_c_0 = 1'b1;
        data_in_c_1  = 8'hF0;
        valid_in_c_1 = 1'b1;
        repeat (4) @(negedge clk_8f);
        reset = 1'b0;
        @(negedge clk_8f);
        chk("midreset_out0", 32'(out0_a), 32'd0);
        chk("midreset_out1", 32'(out1_a), 32'd0);
        chk("midreset_ready", 32'(ready_a), 32'd0);
        chk("midreset_sync_done", 32'(sync_done_a), 32'd0);
        reset = 1'b1;
        valid_in_c_0 = 1'b0;
        valid_in_c_1 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_8f);
            cnt++;
            if (ready_a === 1'b1) break;
        end
        chk("midreset_edges_to_ready", 32'(cnt), 32'd32);

        // Random traffic; inputs change every cycle, only load-edge values matter.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_8f);
            data_in_c_0  = 8'($urandom);
            data_in_c_1  = 8'($urandom);
            valid_in_c_0 = 1'($urandom_range(0, 1));
            valid_in_c_1 = 1'($urandom_range(0, 1));
            if (k == 200) reset = 1'b0;
            if (k == 202) reset = 1'b1;
        end

        @(negedge clk_8f);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
